// File: rtl/piece_ctrl.sv
// piece_ctrl: falling-tetromino sequencer covering spawn, cell-by-cell move checks, lock and line-clear handoff.
// Defining PIECE_CTRL_HARD_DROP_EN adds the hard_drop port and the drop-until-lock behaviour.
//
// state   | meaning
// IDLE    | waiting for start
// SPAWN   | load the next piece as the candidate at (3,0)
// READY   | piece live, accepting one command per cycle
// CHECK   | 16-cycle scan of candidate cells against walls, floor and board
// COMMIT  | adopt the candidate, or lock / reject / game over on collision
// LOCK    | 16-cycle write of the current shape into the board
// CLEAR   | waiting for the board line-clear to finish
// OVER    | spawn collided; waiting for start
module piece_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              tick,
    input  logic              mv_left,
    input  logic              mv_right,
    input  logic              mv_rot,
`ifdef PIECE_CTRL_HARD_DROP_EN
    input  logic              hard_drop,
`endif
    input  logic [2:0]        next_piece,
    output logic              piece_req,
    output logic [9:0]        blk_num,
    output logic [9:0]        blk_rot,
    input  logic [15:0]       blk_matrix,
    output logic [4:0]        brd_row,
    output logic [3:0]        brd_col,
    input  logic              brd_occ,
    output logic              lock_we,
    output logic              clear_start,
    input  logic              clear_done,
    output logic signed [4:0] pos_x,
    output logic [4:0]        pos_y,
    output logic              active,
    output logic              game_over
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SPAWN  = 3'd1;
    localparam logic [2:0] S_READY  = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_LOCK   = 3'd5;
    localparam logic [2:0] S_CLEAR  = 3'd6;
    localparam logic [2:0] S_OVER   = 3'd7;

    logic [2:0]        state;
    logic [2:0]        cur_num, cand_num;
    logic [1:0]        cur_rot, cand_rot;
    logic signed [4:0] cand_x;
    logic [4:0]        cand_y;
    logic [3:0]        k;
    logic              coll, mv_down, mv_hard, from_spawn, tick_pend;
    logic              hd;

`ifdef PIECE_CTRL_HARD_DROP_EN
    assign hd = hard_drop;
`else
    assign hd = 1'b0;
`endif

    logic              in_check, in_lock;
    logic [2:0]        sel_num;
    logic [1:0]        sel_rot;
    logic signed [4:0] base_x;
    logic [4:0]        base_y;
    logic [5:0]        col_w, row_w;
    logic              cell_set, out_of_range, hit;

    assign in_check = (state == S_CHECK);
    assign in_lock  = (state == S_LOCK);
    // The lookup shows the candidate while checking and the committed piece otherwise.
    assign sel_num  = in_check ? cand_num : cur_num;
    assign sel_rot  = in_check ? cand_rot : cur_rot;
    assign base_x   = in_lock ? pos_x : cand_x;
    assign base_y   = in_lock ? pos_y : cand_y;
    assign col_w    = {base_x[4], base_x} + {4'b0000, k[1:0]};
    assign row_w    = {1'b0, base_y} + {4'b0000, k[3:2]};

    assign cell_set     = blk_matrix[4'd15 - k];
    assign out_of_range = col_w[5] | (col_w > 6'd9) | (row_w > 6'd19);
    assign hit          = cell_set & (out_of_range | brd_occ);

    always_comb begin
        brd_row = '0;
        brd_col = '0;
        if ((in_check || in_lock) && !out_of_range) begin
            brd_row = row_w[4:0];
            brd_col = col_w[3:0];
        end
    end

    assign blk_num   = {7'b0, sel_num};
    assign blk_rot   = {8'b0, sel_rot};
    assign lock_we   = in_lock & cell_set;
    assign piece_req = (state == S_SPAWN);
    assign active    = ((state == S_READY) || in_check || (state == S_COMMIT)) && !from_spawn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cur_num     <= '0;
            cur_rot     <= '0;
            cand_num    <= '0;
            cand_rot    <= '0;
            cand_x      <= '0;
            cand_y      <= '0;
            pos_x       <= '0;
            pos_y       <= '0;
            k           <= '0;
            coll        <= 1'b0;
            mv_down     <= 1'b0;
            mv_hard     <= 1'b0;
            from_spawn  <= 1'b0;
            tick_pend   <= 1'b0;
            clear_start <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            clear_start <= 1'b0;
            if (tick && state != S_READY) tick_pend <= 1'b1;
            case (state)
                S_IDLE: if (start) state <= S_SPAWN;
                S_OVER: if (start) begin
                    state     <= S_SPAWN;
                    game_over <= 1'b0;
                end
                S_SPAWN: begin
                    cand_num   <= (next_piece > 3'd4) ? 3'd0 : next_piece;
                    cand_rot   <= '0;
                    cand_x     <= 5'sd3;
                    cand_y     <= '0;
                    from_spawn <= 1'b1;
                    mv_down    <= 1'b0;
                    mv_hard    <= 1'b0;
                    k          <= '0;
                    coll       <= 1'b0;
                    state      <= S_CHECK;
                end
                S_READY: begin
                    cand_num   <= cur_num;
                    cand_rot   <= cur_rot;
                    cand_x     <= pos_x;
                    cand_y     <= pos_y;
                    mv_down    <= 1'b0;
                    mv_hard    <= 1'b0;
                    from_spawn <= 1'b0;
                    k          <= '0;
                    coll       <= 1'b0;
                    if (hd) begin
                        cand_y  <= pos_y + 5'd1;
                        mv_hard <= 1'b1;
                        state   <= S_CHECK;
                        if (tick) tick_pend <= 1'b1;
                    end else if (tick || tick_pend) begin
                        cand_y    <= pos_y + 5'd1;
                        mv_down   <= 1'b1;
                        tick_pend <= 1'b0;
                        state     <= S_CHECK;
                    end else if (mv_rot) begin
                        cand_rot <= cur_rot + 2'd1;
                        state    <= S_CHECK;
                    end else if (mv_left) begin
                        cand_x <= pos_x - 5'sd1;
                        state  <= S_CHECK;
                    end else if (mv_right) begin
                        cand_x <= pos_x + 5'sd1;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    coll <= coll | hit;
                    k    <= k + 4'd1;
                    if (k == 4'd15) state <= S_COMMIT;
                end
                S_COMMIT: begin
                    k <= '0;
                    if (!coll) begin
                        cur_num    <= cand_num;
                        cur_rot    <= cand_rot;
                        pos_x      <= cand_x;
                        pos_y      <= cand_y;
                        from_spawn <= 1'b0;
                        if (mv_hard) begin
                            cand_y <= cand_y + 5'd1;
                            state  <= S_CHECK;
                        end else begin
                            state <= S_READY;
                        end
                    end else if (mv_down || mv_hard) begin
                        state <= S_LOCK;
                        if (mv_hard) tick_pend <= 1'b0;
                    end else if (from_spawn) begin
                        state      <= S_OVER;
                        game_over  <= 1'b1;
                        from_spawn <= 1'b0;
                    end else begin
                        state <= S_READY;
                    end
                end
                S_LOCK: begin
                    k <= k + 4'd1;
                    if (k == 4'd15) begin
                        clear_start <= 1'b1;
                        state       <= S_CLEAR;
                    end
                end
                S_CLEAR: if (clear_done) state <= S_SPAWN;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
